// File: rtl/bf16_pkg.sv
// bf16_pkg: shared BF16 types, opcodes, flag indices, constants and classification helpers
package bf16_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MIN = 4'b0010,
    OP_MAX = 4'b0011,
    OP_MUL = 4'b0100,
    OP_FMA = 4'b0111
  } op_e;
  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  localparam logic [15:0] QNAN     = 16'h7FC0;
  localparam logic [15:0] ONE      = 16'h3F80;
  localparam logic [15:0] NEG_ZERO = 16'h8000;
  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [7:0] mant;
    logic       is_zero;
    logic       is_inf;
    logic       is_nan;
    logic       is_snan;
  } fp_t;
  function automatic logic is_nan(input logic [15:0] x);
    return x[14:7] == 8'hFF && x[6:0] != 7'd0;
  endfunction
  function automatic logic is_snan(input logic [15:0] x);
    return is_nan(x) && !x[6];
  endfunction
  function automatic fp_t unpack(input logic [15:0] x);
    fp_t u;
    u.sign    = x[15];
    u.exp     = x[14:7];
    u.is_zero = x[14:7] == 8'h00;
    u.mant    = u.is_zero ? 8'h00 : {1'b1, x[6:0]};
    u.is_inf  = x[14:7] == 8'hFF && x[6:0] == 7'd0;
    u.is_nan  = is_nan(x);
    u.is_snan = is_snan(x);
    return u;
  endfunction
endpackage

// File: rtl/bf16_fma_core.sv
// bf16_fma_core: combinational a*b+c with single RNE rounding; ports a,b,c in, result/flags {NV,OF,UF,NX} out
module bf16_fma_core
  import bf16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  fp_t ua, ub, uc;
  logic sp, p_zero, p_big, eff_sub, neg, rs, g, st, any_nan, any_snan, p_inf, inv;
  logic [15:0] p, lm, sm;
  logic signed [11:0] ep, ecx, le, dd, e, er;
  logic [5:0] sh, msb;
  logic [95:0] wide;
  logic [47:0] s48;
  logic [48:0] sum, mag, norm;
  logic [8:0] rnd;
  logic [6:0] frac;
  assign ua = unpack(a);
  assign ub = unpack(b);
  assign uc = unpack(c);
  assign sp = ua.sign ^ ub.sign;
  assign p_zero = ua.is_zero | ub.is_zero;
  assign p = ua.mant * ub.mant;
  // exponents of the LSB of the 16-bit product and of c widened to 16 bits
  assign ep = $signed({4'd0, ua.exp} + {4'd0, ub.exp} - 12'd268);
  assign ecx = $signed({4'd0, uc.exp} - 12'd142);
  assign p_big = uc.is_zero | (!p_zero && ep >= ecx);
  assign lm = p_big ? p : {uc.mant, 8'd0};
  assign sm = p_big ? {uc.mant, 8'd0} : p;
  assign le = p_big ? ep : ecx;
  assign dd = p_big ? ep - ecx : ecx - ep;
  assign sh = (dd[11:6] != 6'd0) ? 6'd63 : dd[5:0];
  // larger term sits at [47:32]; bits of the smaller one shifted past bit 0 are jammed into a sticky LSB
  assign wide = {sm, 80'd0} >> sh;
  assign s48 = wide[95:48] | {47'd0, |wide[47:0]};
  assign eff_sub = sp ^ uc.sign;
  assign sum = eff_sub ? {1'b0, lm, 32'd0} - {1'b0, s48} : {1'b0, lm, 32'd0} + {1'b0, s48};
  assign neg = eff_sub & sum[48];
  assign mag = neg ? ~sum + 49'd1 : sum;
  assign rs = (p_big ? sp : uc.sign) ^ neg;
  always_comb begin
    msb = 6'd0;
    for (int i = 0; i < 49; i++) if (mag[i]) msb = 6'(i);
  end
  assign norm = mag << (6'd48 - msb);
  assign g = norm[40];
  assign st = |norm[39:0];
  assign rnd = {1'b0, norm[48:41]} + {8'd0, g & (st | norm[41])};
  assign frac = rnd[8] ? rnd[7:1] : rnd[6:0];
  assign e = le + $signed({6'd0, msb}) + 12'sd95;
  assign er = e + $signed({11'd0, rnd[8]});
  assign any_nan = ua.is_nan | ub.is_nan | uc.is_nan;
  assign any_snan = ua.is_snan | ub.is_snan | uc.is_snan;
  assign p_inf = ua.is_inf | ub.is_inf;
  assign inv = any_snan | (ua.is_inf & ub.is_zero) | (ub.is_inf & ua.is_zero) | (p_inf & uc.is_inf & eff_sub);
  always_comb begin
    result = {rs, er[7:0], frac};
    flags = 4'd0;
    if (any_nan | inv) begin
      result = QNAN;
      flags[FLAG_NV] = inv;
    end else if (p_inf) begin
      result = {sp, 8'hFF, 7'd0};
    end else if (uc.is_inf) begin
      result = {uc.sign, 8'hFF, 7'd0};
    end else if (mag == 49'd0) begin
      result = {p_zero & uc.is_zero & sp & uc.sign, 15'd0};
    end else if (er >= 12'sd255) begin
      result = {rs, 8'hFF, 7'd0};
      flags[FLAG_OF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else if (er <= 12'sd0) begin
      result = {rs, 15'd0};
      flags[FLAG_UF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else begin
      flags[FLAG_NX] = g | st;
    end
  end
endmodule

// File: rtl/bf16_accel_top.sv
// bf16_accel_top: BF16 add/sub/mul/min/max/fma unit; clk, reset (sync active-low), enable, operand_a/b/c, operation -> registered result, fpcsr {NV,OF,UF,NX}, valid; BF16_FMA_EN enables opcode 0111
module bf16_accel_top
  import bf16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] operand_a,
  input  logic [15:0] operand_b,
  input  logic [15:0] operand_c,
  input  logic [3:0]  operation,
  output logic [15:0] result,
  output logic [3:0]  fpcsr,
  output logic        valid
);
  op_e op;
  logic is_add, is_sub, is_mul, is_fma, is_mm, arith, a_nan, b_nan;
  logic [15:0] core_b, core_c, fma_c, core_res, ka, kb, mm_sel, mm_res, nres;
  logic [3:0] core_flg, nflg;
  assign op = op_e'(operation);
  assign is_add = op == OP_ADD;
  assign is_sub = op == OP_SUB;
  assign is_mul = op == OP_MUL;
  assign is_mm = op == OP_MIN || op == OP_MAX;
`ifdef BF16_FMA_EN
  assign is_fma = op == OP_FMA;
  assign fma_c = operand_c;
`else
  logic unused_c;
  assign unused_c = ^operand_c;
  assign is_fma = 1'b0;
  assign fma_c = NEG_ZERO;
`endif
  assign arith = is_add | is_sub | is_mul | is_fma;
  assign core_b = (is_add | is_sub) ? ONE : operand_b;
  assign core_c = is_add ? operand_b : is_sub ? {~operand_b[15], operand_b[14:0]} : is_mul ? NEG_ZERO : fma_c;
  bf16_fma_core u_core (
    .a      (operand_a),
    .b      (core_b),
    .c      (core_c),
    .result (core_res),
    .flags  (core_flg)
  );
  // sign-magnitude mapped to an unsigned total order, so -0 sorts below +0
  assign ka = operand_a[15] ? ~operand_a : {1'b1, operand_a[14:0]};
  assign kb = operand_b[15] ? ~operand_b : {1'b1, operand_b[14:0]};
  assign a_nan = is_nan(operand_a);
  assign b_nan = is_nan(operand_b);
  assign mm_sel = (op == OP_MIN) ? ((kb < ka) ? operand_b : operand_a) : ((kb > ka) ? operand_b : operand_a);
  assign mm_res = (a_nan & b_nan) ? QNAN : a_nan ? operand_b : b_nan ? operand_a : mm_sel;
  assign nres = arith ? core_res : is_mm ? mm_res : QNAN;
  assign nflg = arith ? core_flg : is_mm ? {is_snan(operand_a) | is_snan(operand_b), 3'b000} : 4'(1) << FLAG_NV;
  always_ff @(posedge clk) begin
    if (!reset) begin
      result <= 16'd0;
      fpcsr <= 4'd0;
      valid <= 1'b0;
    end else begin
      valid <= enable;
      if (enable) begin
        result <= nres;
        fpcsr <= nflg;
      end
    end
  end
endmodule

// File: tb/tb_bf16_accel_top.sv
// tb_bf16_accel_top: directed scoreboard bench for bf16_accel_top
module tb_bf16_accel_top;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, valid;
  logic [15:0] operand_a = '0, operand_b = '0, operand_c = '0, result;
  logic [3:0] operation = '0, fpcsr;
  typedef struct {
    string       tag;
    logic [15:0] res;
    logic [3:0]  flg;
  } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  logic [15:0] last_res = '0;
  logic [3:0] last_flg = '0;
`ifdef BF16_FMA_EN
  localparam bit FMA = 1'b1;
`else
  localparam bit FMA = 1'b0;
`endif

  bf16_accel_top dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .operand_c (operand_c),
    .operation (operation),
    .result    (result),
    .fpcsr     (fpcsr),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] er, input logic [3:0] ef);
    exp_t x;
    @(negedge clk);
    enable = 1'b1;
    operation = op;
    operand_a = a;
    operand_b = b;
    operand_c = c;
    sb.push_back('{tag, er, ef});
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 16'(valid), 16'd1);
    if (valid && sb.size() > 0) begin
      x = sb.pop_front();
      check({x.tag, ".result"}, result, x.res);
      check({x.tag, ".fpcsr"}, 16'(fpcsr), 16'(x.flg));
      last_res = x.res;
      last_flg = x.flg;
    end
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    enable = 1'b0;
    operation = 4'(2);
    operand_a = 16'(32'($urandom));
    operand_b = 16'(32'($urandom));
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 16'(valid), 16'd0);
    check({tag, ".result"}, result, last_res);
    check({tag, ".fpcsr"}, 16'(fpcsr), 16'(last_flg));
  endtask

  initial begin
    enable = 1'b1;
    operation = 4'b0000;
    operand_a = 16'h3F80;
    operand_b = 16'h3F80;
    repeat (10) @(posedge clk);
    #1;
    check("rst.result", result, 16'h0000);
    check("rst.fpcsr", 16'(fpcsr), 16'h0);
    check("rst.valid", 16'(valid), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    issue("min_first", 4'b0010, 16'h4000, 16'h3C00, 16'h0, 16'h3C00, 4'h0);
    issue("fma1", 4'b0111, 16'h4000, 16'h3F90, 16'h40A0, FMA ? 16'h40E8 : 16'h7FC0, FMA ? 4'h0 : 4'h8);
    issue("fma2", 4'b0111, 16'h4000, 16'h4080, 16'h40C0, FMA ? 16'h4160 : 16'h7FC0, FMA ? 4'h0 : 4'h8);
    issue("max_big", 4'b0011, 16'h7C00, 16'h7E00, 16'h0, 16'h7E00, 4'h0);
    issue("max_inf", 4'b0011, 16'h7F80, 16'h0080, 16'h0, 16'h7F80, 4'h0);
    issue("min_small", 4'b0010, 16'h0380, 16'h0400, 16'h0, 16'h0380, 4'h0);
    issue("max_eq", 4'b0011, 16'h3555, 16'h3555, 16'h0, 16'h3555, 4'h0);
    issue("mul_inf0", 4'b0100, 16'h7F80, 16'h0000, 16'h0, 16'h7FC0, 4'h8);
    issue("mul_ovf", 4'b0100, 16'h7F00, 16'h7F00, 16'h0, 16'h7F80, 4'h5);
    issue("max_qnan", 4'b0011, 16'h7FC0, 16'h4000, 16'h0, 16'h4000, 4'h0);
    issue("min_zeros", 4'b0010, 16'h8000, 16'h0000, 16'h0, 16'h8000, 4'h0);
    issue("add_tie", 4'b0000, 16'h3F80, 16'h3B80, 16'h0, 16'h3F80, 4'h1);
    issue("sub_zero", 4'b0001, 16'h4000, 16'h4000, 16'h0, 16'h0000, 4'h0);
    idle("hold");
    issue("rsv_0101", 4'b0101, 16'h3F80, 16'h3F80, 16'h0, 16'h7FC0, 4'h8);
    issue("rsv_1111", 4'b1111, 16'h3F80, 16'h3F80, 16'h0, 16'h7FC0, 4'h8);
    issue("add_1p1", 4'b0000, 16'h3F80, 16'h3F80, 16'h0, 16'h4000, 4'h0);
    issue("sub_neg", 4'b0001, 16'h3F80, 16'h4000, 16'h0, 16'hBF80, 4'h0);
    issue("mul_2x3", 4'b0100, 16'h4000, 16'h4040, 16'h0, 16'h40C0, 4'h0);
    issue("mul_uf", 4'b0100, 16'h0080, 16'h0080, 16'h0, 16'h0000, 4'h3);
    issue("add_tie_up", 4'b0000, 16'h3F80, 16'h3F81, 16'h0, 16'h4000, 4'h1);
    issue("add_negz", 4'b0000, 16'h8000, 16'h8000, 16'h0, 16'h8000, 4'h0);
    issue("add_cancel", 4'b0000, 16'h3F80, 16'hBF80, 16'h0, 16'h0000, 4'h0);
    issue("add_infinf", 4'b0000, 16'h7F80, 16'hFF80, 16'h0, 16'h7FC0, 4'h8);
    issue("add_qnan", 4'b0000, 16'h7FC0, 16'h3F80, 16'h0, 16'h7FC0, 4'h0);
    issue("min_snan", 4'b0010, 16'h7F81, 16'h3F80, 16'h0, 16'h3F80, 4'h8);
    issue("max_2nan", 4'b0011, 16'h7FC1, 16'hFFC0, 16'h0, 16'h7FC0, 4'h0);
    issue("mul_sq", 4'b0100, 16'h3FC0, 16'hBFC0, 16'h0, 16'hC010, 4'h0);
    idle("hold2");
    check("sb.empty", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
